// File: rtl/ok8_midi_pkg.sv
// ok8_midi_pkg: shared constants, state encodings and helpers for the OK-8
// MIDI output engine (ok8_midi_tx and its byte serializer ok8_midi_byte_tx).
package ok8_midi_pkg;

  // MIDI status nibbles and the release velocity used by Note Off.
  localparam logic [7:0] NOTE_ON  = 8'h90;
  localparam logic [7:0] NOTE_OFF = 8'h80;
  localparam logic [7:0] OFF_VEL  = 8'h40;

  // Clock cycles per serial bit. Integer division truncates, so any
  // fractional remainder shows up as a small baud-rate error.
  function automatic int bit_cycles(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Index of the lowest set bit of a six-slot byte mask. Returns 0 for an
  // empty mask; callers test for an empty mask before using the result.
  function automatic logic [2:0] first_set(input logic [5:0] m);
    first_set = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (m[i]) first_set = 3'(i);
    end
  endfunction

  typedef enum logic [1:0] {
    CTL_IDLE,
    CTL_LOAD,
    CTL_SEND,
    CTL_NEXT
  } ctl_state_e;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_START,
    SER_DATA,
    SER_STOP
  } ser_state_e;

endpackage

// File: rtl/ok8_midi_byte_tx.sv
// ok8_midi_byte_tx: 8N1 serializer, one start bit, 8 data bits LSB first,
// one stop bit, each BIT_CYCLES clocks wide.
//   clk12, n_reset : clock, asynchronous active-low reset
//   start, data    : request to send data; it is taken when idle or done
//   idle           : nothing being sent
//   done           : last cycle of the stop bit; a byte offered now starts
//                    on the next cycle with no idle gap
//   tx             : serial output, idle high
module ok8_midi_byte_tx
  import ok8_midi_pkg::*;
#(
  parameter int BIT_CYCLES = 384
) (
  input  logic       clk12,
  input  logic       n_reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       idle,
  output logic       done,
  output logic       tx
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  ser_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end = (cnt_q == LAST);
  assign idle    = (state_q == SER_IDLE);
  assign done    = (state_q == SER_STOP) && bit_end;
  assign tx      = tx_q;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;

    case (state_q)
      SER_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = SER_DATA;
          tx_d    = sh_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SER_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = SER_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SER_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = SER_IDLE;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    // A byte offered during the final stop cycle replaces the return to
    // idle, which is what makes multi-byte messages gapless.
    if (start && (idle || done)) begin
      sh_d    = data;
      bit_d   = 3'd0;
      cnt_d   = '0;
      state_d = SER_START;
      tx_d    = 1'b0;
    end
  end

  // NOTE: flops use non-blocking assignment so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk12 or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= SER_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/ok8_midi_tx.sv
// ok8_midi_tx: turns OK-8 note commands into MIDI Note Off / Note On
// messages on a serial line and tracks the sounding note.
//   clk12, n_reset     : clock, asynchronous active-low reset
//   note, note_valid   : command (0 silence, 1..127 note, >=128 ignored)
//   note_ready         : a command can be accepted
//   midi_tx            : MIDI serial out, idle high
//   busy               : a byte is on the wire
// Build option OK8_MIDI_RUNNING_STATUS_EN: Note Off is sent as Note On with
// velocity 0 and a status byte equal to the last one sent is omitted.
module ok8_midi_tx
  import ok8_midi_pkg::*;
#(
  parameter int         CLK_HZ   = 12000000,
  parameter int         BAUD     = 31250,
  parameter int         CHANNEL  = 0,
  parameter logic [7:0] VELOCITY = 8'h64
) (
  input  logic       clk12,
  input  logic       n_reset,
  input  logic [7:0] note,
  input  logic       note_valid,
  output logic       note_ready,
  output logic       midi_tx,
  output logic       busy
);

  localparam int BIT_CYCLES = bit_cycles(CLK_HZ, BAUD);
  localparam logic [7:0] ON_STAT = NOTE_ON | {4'h0, 4'(CHANNEL)};
`ifdef OK8_MIDI_RUNNING_STATUS_EN
  localparam logic [7:0] OFF_STAT = ON_STAT;
  localparam logic [7:0] OFF_V    = 8'h00;
`else
  localparam logic [7:0] OFF_STAT = NOTE_OFF | {4'h0, 4'(CHANNEL)};
  localparam logic [7:0] OFF_V    = OFF_VEL;
`endif

  ctl_state_e ctl_q, ctl_d;
  logic [2:0] idx_q, idx_d;
  // One bit per sequence slot: off status, off note, off vel, on status,
  // on note, on vel. Cleared slots are skipped by idx.
  logic [5:0] mask_q, mask_d;
  logic [6:0] cur_q, cur_d;          // 0 means no note sounding
  logic [6:0] off_note_q, off_note_d;
  logic [6:0] on_note_q, on_note_d;
  logic [7:0] byte_q, byte_d;
`ifdef OK8_MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status_q, last_status_d;  // 0 never matches a status byte
`endif

  logic       do_off, do_on, off_stat_en, on_stat_en;
  logic [5:0] new_mask;
  logic [7:0] slot_byte;
  logic       ser_start, ser_idle, ser_done;

  assign note_ready = (ctl_q == CTL_IDLE) && ser_idle;
  assign busy       = !ser_idle;

  // Command decode against the sounding note.
  always_comb begin
    do_off = 1'b0;
    do_on  = 1'b0;
    if (!note[7]) begin
      if (note[6:0] == 7'd0) begin
        do_off = (cur_q != 7'd0);
      end else if (note[6:0] != cur_q) begin
        do_off = (cur_q != 7'd0);
        do_on  = 1'b1;
      end
    end
`ifdef OK8_MIDI_RUNNING_STATUS_EN
    // Off and On share one status here, so an On following an Off in the
    // same sequence never needs its own status byte.
    off_stat_en = do_off && (last_status_q != ON_STAT);
    on_stat_en  = do_on && !do_off && (last_status_q != ON_STAT);
`else
    off_stat_en = do_off;
    on_stat_en  = do_on;
`endif
    new_mask = {do_on, do_on, on_stat_en, do_off, do_off, off_stat_en};
  end

  always_comb begin
    case (idx_q)
      3'd0:    slot_byte = OFF_STAT;
      3'd1:    slot_byte = {1'b0, off_note_q};
      3'd2:    slot_byte = OFF_V;
      3'd3:    slot_byte = ON_STAT;
      3'd4:    slot_byte = {1'b0, on_note_q};
      default: slot_byte = VELOCITY;
    endcase
  end

  always_comb begin
    ctl_d      = ctl_q;
    idx_d      = idx_q;
    mask_d     = mask_q;
    cur_d      = cur_q;
    off_note_d = off_note_q;
    on_note_d  = on_note_q;
    byte_d     = byte_q;
    ser_start  = 1'b0;
`ifdef OK8_MIDI_RUNNING_STATUS_EN
    last_status_d = last_status_q;
`endif

    case (ctl_q)
      CTL_IDLE: begin
        if (note_valid && note_ready) begin
          if (!note[7]) cur_d = note[6:0];
          off_note_d = cur_q;
          on_note_d  = note[6:0];
          if (new_mask != 6'd0) begin
            mask_d = new_mask;
            idx_d  = first_set(new_mask);
            ctl_d  = CTL_LOAD;
          end
        end
      end
      CTL_LOAD: begin
        byte_d = slot_byte;
        ctl_d  = CTL_SEND;
      end
      CTL_SEND: begin
        ser_start = 1'b1;
        if (ser_idle || ser_done) begin
          mask_d = mask_q & ~(6'd1 << idx_q);
`ifdef OK8_MIDI_RUNNING_STATUS_EN
          if (idx_q == 3'd0 || idx_q == 3'd3) last_status_d = byte_q;
`endif
          ctl_d = CTL_NEXT;
        end
      end
      CTL_NEXT: begin
        if (mask_q == 6'd0) begin
          ctl_d = CTL_IDLE;
        end else begin
          idx_d = first_set(mask_q);
          ctl_d = CTL_LOAD;
        end
      end
      default: ctl_d = CTL_IDLE;
    endcase
  end

  always_ff @(posedge clk12 or negedge n_reset) begin
    if (!n_reset) begin
      ctl_q      <= CTL_IDLE;
      idx_q      <= 3'd0;
      mask_q     <= 6'd0;
      cur_q      <= 7'd0;
      off_note_q <= 7'd0;
      on_note_q  <= 7'd0;
      byte_q     <= 8'd0;
    end else begin
      ctl_q      <= ctl_d;
      idx_q      <= idx_d;
      mask_q     <= mask_d;
      cur_q      <= cur_d;
      off_note_q <= off_note_d;
      on_note_q  <= on_note_d;
      byte_q     <= byte_d;
    end
  end

`ifdef OK8_MIDI_RUNNING_STATUS_EN
  always_ff @(posedge clk12 or negedge n_reset) begin
    if (!n_reset) last_status_q <= 8'd0;
    else          last_status_q <= last_status_d;
  end
`endif

  ok8_midi_byte_tx #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_byte_tx (
    .clk12  (clk12),
    .n_reset(n_reset),
    .start  (ser_start),
    .data   (byte_q),
    .idle   (ser_idle),
    .done   (ser_done),
    .tx     (midi_tx)
  );

endmodule

// File: tb/tb_ok8_midi_tx.sv
// tb_ok8_midi_tx: scoreboard bench for ok8_midi_tx. The driver pushes the
// bytes a MIDI reference model predicts; an independent serial monitor
// decodes midi_tx and pops/compares them. A reduced clock rate keeps the
// run short (BIT_CYCLES = 1200000/31250 = 38, truncated from 38.4).
module tb_ok8_midi_tx;

  localparam int         CLK_HZ   = 1200000;
  localparam int         BAUD     = 31250;
  localparam int         CHANNEL  = 3;
  localparam logic [7:0] VELOCITY = 8'h64;
  localparam int         BC       = CLK_HZ / BAUD;
  localparam int         FRAME    = 10 * BC;

  typedef struct {
    logic [7:0] b;
    bit         first;
    int         start;
  } exp_t;

  logic       clk12 = 1'b0;
  logic       n_reset = 1'b0;
  logic [7:0] note = 8'd0;
  logic       note_valid = 1'b0;
  logic       note_ready, midi_tx, busy;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  exp_t       exp_q[$];
  logic [7:0] seq_q[$];
  logic [7:0] m_cur = 8'd0;   // reference model: sounding note, 0 = none
  logic [7:0] m_last = 8'd0;  // reference model: last status sent

  ok8_midi_tx #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNEL(CHANNEL), .VELOCITY(VELOCITY)
  ) dut (
    .clk12     (clk12),
    .n_reset   (n_reset),
    .note      (note),
    .note_valid(note_valid),
    .note_ready(note_ready),
    .midi_tx   (midi_tx),
    .busy      (busy)
  );

  always #5 clk12 = ~clk12;
  always @(posedge clk12) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_msg(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2);
`ifdef OK8_MIDI_RUNNING_STATUS_EN
    if (st != m_last) seq_q.push_back(st);
`else
    seq_q.push_back(st);
`endif
    m_last = st;
    seq_q.push_back(d1);
    seq_q.push_back(d2);
  endtask

  task automatic model_off(input logic [7:0] n);
`ifdef OK8_MIDI_RUNNING_STATUS_EN
    model_msg(8'h90 | 8'(CHANNEL), n, 8'h00);
`else
    model_msg(8'h80 | 8'(CHANNEL), n, 8'h40);
`endif
  endtask

  task automatic model_cmd(input logic [7:0] n);
    seq_q.delete();
    if (n < 8'd128) begin
      if (n == 8'd0) begin
        if (m_cur != 8'd0) model_off(m_cur);
        m_cur = 8'd0;
      end else if (n != m_cur) begin
        if (m_cur != 8'd0) model_off(m_cur);
        model_msg(8'h90 | 8'(CHANNEL), n, VELOCITY);
        m_cur = n;
      end
    end
  endtask

  // ---------------- driver helpers ----------------
  // Leaves note_valid high; the caller decides when to drop it.
  task automatic accept_cmd(input logic [7:0] n, output int acc, output int nb);
    note = n;
    note_valid = 1'b1;
    for (int t = 0; t < 8 * FRAME && note_ready !== 1'b1; t++) @(negedge clk12);
    if (note_ready !== 1'b1) begin
      check("accept_timeout", 32'(note_ready), 32'd1);
      note_valid = 1'b0;
      acc = cyc;
      nb = 0;
      return;
    end
    @(posedge clk12);
    #1;
    acc = cyc;
    model_cmd(n);
    nb = seq_q.size();
    foreach (seq_q[i]) exp_q.push_back('{b: seq_q[i], first: (i == 0), start: acc + 2});
  endtask

  task automatic wait_done(input int acc, input int nb);
    bit ok;
    if (nb == 0) begin
      ok = 1'b1;
      for (int t = 0; t < 2 * BC; t++) begin
        @(negedge clk12);
        if (midi_tx !== 1'b1 || busy !== 1'b0 || note_ready !== 1'b1) ok = 1'b0;
      end
      check("noop_quiet", 32'(ok), 32'd1);
    end else begin
      @(negedge clk12);
      check("ready_drop", 32'(note_ready), 32'd0);
      @(negedge clk12);
      check("busy_before_start", 32'(busy), 32'd0);
      @(negedge clk12);
      check("busy_at_start", 32'(busy), 32'd1);
      ok = 1'b1;
      for (int t = 0; t < nb * FRAME + 20 && note_ready !== 1'b1; t++) begin
        if (busy !== 1'b1) ok = 1'b0;
        @(negedge clk12);
      end
      check("busy_held", 32'(ok), 32'd1);
      check("ready_return_cycle", 32'(cyc), 32'(acc + 2 + nb * FRAME));
      check("busy_end", 32'(busy), 32'd0);
    end
  endtask

  task automatic do_cmd(input logic [7:0] n);
    int acc, nb;
    accept_cmd(n, acc, nb);
    note_valid = 1'b0;
    wait_done(acc, nb);
  endtask

  // ---------------- monitor: serial decode + scoreboard ----------------
  initial begin : monitor
    int         st, prev_st;
    logic [9:0] fr;
    bit         ok, ab;
    exp_t       e;
    prev_st = 0;
    forever begin
      @(negedge clk12);
      if (n_reset === 1'b1 && midi_tx === 1'b0) begin
        st = cyc;
        ok = 1'b1;
        ab = 1'b0;
        fr = '0;
        for (int k = 0; k < FRAME; k++) begin
          if (k > 0) @(negedge clk12);
          if (n_reset !== 1'b1) begin
            ab = 1'b1;
            break;
          end
          if (k % BC == 0) fr[k / BC] = midi_tx;
          else if (midi_tx !== fr[k / BC]) ok = 1'b0;
        end
        if (!ab) begin
          check("frame_shape", {29'd0, ok, fr[0], fr[9]}, 32'b101);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got 0x%0h expected none (cycle %0d)", fr[8:1], cyc);
          end else begin
            e = exp_q.pop_front();
            check("byte", 32'(fr[8:1]), 32'(e.b));
            if (e.first) check("start_latency", 32'(st), 32'(e.start));
            else         check("back_to_back", 32'(st), 32'(prev_st + FRAME));
          end
          prev_st = st;
        end
      end
    end
  end

  initial begin : watchdog
    #(2 * 10 * 90000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : driver
    int         acc, nb, target;
    logic [7:0] n;

    repeat (3) @(negedge clk12);
    check("reset_note_ready", 32'(note_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_midi_tx", 32'(midi_tx), 32'd1);
    #1 n_reset = 1'b1;
    repeat (2) @(negedge clk12);

    // Directed: on, change, repeat, ignored, off, silent off, on again.
    do_cmd(8'h3C);
    do_cmd(8'h40);
    do_cmd(8'h40);
    do_cmd(8'hC5);
    do_cmd(8'h00);
    do_cmd(8'h00);
    do_cmd(8'h40);

    // note_valid held across a sequence: next command waits for note_ready.
    accept_cmd(8'h50, acc, nb);
    note = 8'h22;
    wait_done(acc, nb);
    accept_cmd(8'h22, acc, nb);
    note_valid = 1'b0;
    wait_done(acc, nb);

    // Randomized commands against the model.
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    n = 8'd0;
        2:       n = 8'(128 + $urandom_range(0, 127));
        3:       n = m_cur;
        default: n = 8'($urandom_range(1, 127));
      endcase
      do_cmd(n);
    end

    // Reset pulse in the middle of the second data bit of the first byte.
    n = (m_cur == 8'h11) ? 8'h12 : 8'h11;
    accept_cmd(n, acc, nb);
    note_valid = 1'b0;
    target = acc + 2 + 2 * BC + BC / 2;
    while (cyc < target) @(negedge clk12);
    #1 n_reset = 1'b0;
    #1 check("reset_async_midi_tx", 32'(midi_tx), 32'd1);
    @(negedge clk12);
    check("reset_mid_busy", 32'(busy), 32'd0);
    check("reset_mid_note_ready", 32'(note_ready), 32'd1);
    #1 n_reset = 1'b1;
    exp_q.delete();
    m_cur = 8'd0;
    m_last = 8'd0;
    repeat (2) @(negedge clk12);
    do_cmd(8'h3C);

    repeat (4) @(negedge clk12);
    check("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
